// File: rtl/vlsu_vaddr_seq.sv
// VRF bank address sequencer for one VLSU register access: one request in, one {set,off}
// per beat out, wrapping inside the addressed vreg/areg with a one-cycle accept latency.
module vlsu_vaddr_seq #(
  parameter int unsigned NrVregs      = 16,
  parameter int unsigned NrAregs      = 16,
  parameter int unsigned NrBanks      = 8,
  parameter int unsigned NrSetPerVreg = 4,
  parameter int unsigned NrSetPerAreg = 8,
  localparam int unsigned VB          = NrSetPerVreg * NrBanks,
  localparam int unsigned AB          = NrSetPerAreg * NrBanks,
  localparam int unsigned AregBaseSet = NrVregs * NrSetPerVreg,
  localparam int unsigned SetBits     = $clog2(NrVregs * NrSetPerVreg + NrAregs * NrSetPerAreg),
  localparam int unsigned OffBits     = $clog2(NrBanks),
  localparam int unsigned BW          = $clog2(AB),
  localparam int unsigned VBW         = $clog2(VB),
  localparam int unsigned RegBits     = $clog2((NrVregs > NrAregs) ? NrVregs : NrAregs),
  localparam int unsigned AddrW       = SetBits + OffBits
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_areg_i,
  input  logic [RegBits-1:0] req_reg_i,
  input  logic [BW-1:0]      req_start_i,
  input  logic [BW-1:0]      req_len_i,
  input  logic               abort_i,
  output logic               addr_valid_o,
  input  logic               addr_ready_i,
  output logic [AddrW-1:0]   addr_o,
  output logic               addr_last_o,
  output logic               busy_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_r;
  logic [BW-1:0]      bidx_r;
  logic [BW-1:0]      rem_r;
  logic               areg_r;
  logic [RegBits-1:0] reg_r;
  logic               addr_valid_r;
  logic               addr_last_r;
  logic [AddrW-1:0]   addr_r;

  logic               accept_s;
  logic               beat_s;
  logic [BW-1:0]      start_bidx_s;
  logic [BW-1:0]      next_bidx_s;

  // A vreg only spans VB beats, so its index lives in the low VBW bits.
  function automatic logic [BW-1:0] start_idx(input logic areg, input logic [BW-1:0] start);
    logic [BW-1:0] idx;
    if (areg) begin
      idx = start;
    end else begin
      idx = BW'(start[VBW-1:0]);
    end
    return idx;
  endfunction

  function automatic logic [BW-1:0] next_idx(input logic areg, input logic [BW-1:0] bidx);
    logic [VBW-1:0] vidx;
    logic [BW-1:0]  idx;
    vidx = bidx[VBW-1:0] + VBW'(1'b1);
    if (areg) begin
      idx = bidx + BW'(1'b1);
    end else begin
      idx = BW'(vidx);
    end
    return idx;
  endfunction

  function automatic logic [AddrW-1:0] make_addr(input logic areg, input logic [RegBits-1:0] rg,
                                                 input logic [BW-1:0] bidx);
    logic [SetBits-1:0] base;
    logic [SetBits-1:0] set;
    if (areg) begin
      base = SetBits'(AregBaseSet) + SetBits'(rg) * SetBits'(NrSetPerAreg);
    end else begin
      base = SetBits'(rg) * SetBits'(NrSetPerVreg);
    end
    set = base + SetBits'(bidx >> OffBits);
    return {set, bidx[OffBits-1:0]};
  endfunction

  // Request handshake; the only output with a combinational path from addr_ready_i.
  always_comb begin
    req_ready_o  = !abort_i && ((state_r == IDLE) ||
                                ((state_r == RUN) && addr_ready_i && addr_last_r));
    accept_s     = req_valid_i && req_ready_o;
    beat_s       = addr_valid_r && addr_ready_i && !abort_i;
    start_bidx_s = start_idx(req_areg_i, req_start_i);
    next_bidx_s  = next_idx(areg_r, bidx_r);
  end

  // Sequencer FSM with registered address outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      bidx_r       <= {BW{1'b0}};
      rem_r        <= {BW{1'b0}};
      areg_r       <= 1'b0;
      reg_r        <= {RegBits{1'b0}};
      addr_valid_r <= 1'b0;
      addr_last_r  <= 1'b0;
      addr_r       <= {AddrW{1'b0}};
    end else if (abort_i) begin
      state_r      <= IDLE;
      addr_valid_r <= 1'b0;
      addr_last_r  <= 1'b0;
    end else if (accept_s) begin
      state_r      <= RUN;
      bidx_r       <= start_bidx_s;
      rem_r        <= req_len_i;
      areg_r       <= req_areg_i;
      reg_r        <= req_reg_i;
      addr_valid_r <= 1'b1;
      addr_last_r  <= (req_len_i == {BW{1'b0}});
      addr_r       <= make_addr(req_areg_i, req_reg_i, start_bidx_s);
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        RUN: begin
          if (beat_s && addr_last_r) begin
            state_r      <= IDLE;
            addr_valid_r <= 1'b0;
            addr_last_r  <= 1'b0;
          end else if (beat_s) begin
            bidx_r      <= next_bidx_s;
            rem_r       <= rem_r - BW'(1'b1);
            addr_last_r <= (rem_r == BW'(1'b1));
            addr_r      <= make_addr(areg_r, reg_r, next_bidx_s);
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r      <= IDLE;
          addr_valid_r <= 1'b0;
          addr_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_valid_o = addr_valid_r;
  assign addr_last_o  = addr_last_r;
  assign addr_o       = addr_r;
  assign busy_o       = (state_r == RUN);

endmodule

// File: tb/tb_vlsu_vaddr_seq.sv
// Scoreboard bench for vlsu_vaddr_seq: stimulus pushes hand-computed beats, a negedge
// monitor pops and compares every consumed beat.
module tb_vlsu_vaddr_seq;

  typedef struct packed {
    logic [10:0] addr;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic        req_areg;
  logic [3:0]  req_reg;
  logic [5:0]  req_start;
  logic [5:0]  req_len;
  logic        abort;
  logic        addr_valid;
  logic        addr_ready;
  logic [10:0] addr;
  logic        addr_last;
  logic        busy;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  vlsu_vaddr_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_areg_i   (req_areg),
    .req_reg_i    (req_reg),
    .req_start_i  (req_start),
    .req_len_i    (req_len),
    .abort_i      (abort),
    .addr_valid_o (addr_valid),
    .addr_ready_i (addr_ready),
    .addr_o       (addr),
    .addr_last_o  (addr_last),
    .busy_o       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push(input logic [10:0] a, input logic l);
    sb.push_back('{addr: a, last: l});
  endtask

  // Monitor: every consumed beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_ni && addr_valid && addr_ready && !abort) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_addr", 32'(addr), 32'(e.addr));
        check("beat_last", 32'(addr_last), 32'(e.last));
      end
    end
  end

  task automatic issue(input logic ar, input logic [3:0] r, input logic [5:0] s,
                       input logic [5:0] len, input bit b2b);
    bit got;
    got       = 1'b0;
    req_areg  = ar;
    req_reg   = r;
    req_start = s;
    req_len   = len;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) begin
      fail_now("req_accept");
      req_valid = 1'b0;
    end else begin
      if (b2b) check("b2b_accept_on_last", 32'(addr_last), 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("first_beat_latency", 32'(addr_valid), 32'h1);
    end
  endtask

  task automatic consume(input int n);
    int c;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      if (rst_ni && addr_valid && addr_ready && !abort) c++;
      if (c >= n) break;
      @(negedge clk);
    end
    if (c < n) fail_now("consume");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !addr_valid && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain");
    else n_cmp++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_t1();
    push(11'h040, 1'b0);
    push(11'h041, 1'b0);
    push(11'h042, 1'b0);
    push(11'h043, 1'b1);
  endtask

  initial begin
    rst_ni     = 1'b0;
    req_valid  = 1'b0;
    req_areg   = 1'b0;
    req_reg    = 4'd0;
    req_start  = 6'd0;
    req_len    = 6'd0;
    abort      = 1'b0;
    addr_ready = 1'b1;
    #3;
    check("rst_valid", 32'(addr_valid), 32'h0);
    check("rst_last", 32'(addr_last), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // T1 plain vreg sequence
    push_t1();
    issue(1'b0, 4'd2, 6'd0, 6'd3, 1'b0);
    wait_idle();

    // T2 wrap inside vreg1
    push(11'h03E, 1'b0);
    push(11'h03F, 1'b0);
    push(11'h020, 1'b0);
    push(11'h021, 1'b1);
    issue(1'b0, 4'd1, 6'd30, 6'd3, 1'b0);
    wait_idle();

    // T3 single areg beat
    push(11'h209, 1'b1);
    issue(1'b1, 4'd0, 6'd9, 6'd0, 1'b0);
    wait_idle();

    // T4 backpressure mid-sequence
    push_t1();
    issue(1'b0, 4'd2, 6'd0, 6'd3, 1'b0);
    consume(1);
    addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(addr_valid), 32'h1);
      check("stall_addr", 32'(addr), 32'h041);
      check("stall_last", 32'(addr_last), 32'h0);
    end
    @(posedge clk);
    #1 addr_ready = 1'b1;
    wait_idle();

    // T5 back-to-back, second request accepted on the last handshake
    push_t1();
    issue(1'b0, 4'd2, 6'd0, 6'd3, 1'b0);
    push(11'h209, 1'b1);
    issue(1'b1, 4'd0, 6'd9, 6'd0, 1'b1);
    wait_idle();

    // T6 abort on beat 2 with a competing request
    push(11'h040, 1'b0);
    issue(1'b0, 4'd2, 6'd0, 6'd3, 1'b0);
    consume(1);
    abort     = 1'b1;
    req_valid = 1'b1;
    req_areg  = 1'b0;
    req_reg   = 4'd3;
    req_start = 6'd0;
    req_len   = 6'd0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 abort = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(addr_valid), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_sb_empty", 32'(sb.size()), 32'h0);
    @(posedge clk);
    #1;

    // T7 async reset mid-sequence, then a clean request
    push(11'h03E, 1'b0);
    push(11'h03F, 1'b0);
    issue(1'b0, 4'd1, 6'd30, 6'd3, 1'b0);
    consume(2);
    rst_ni = 1'b0;
    #1;
    check("mrst_valid", 32'(addr_valid), 32'h0);
    check("mrst_last", 32'(addr_last), 32'h0);
    check("mrst_addr", 32'(addr), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_ready", 32'(req_ready), 32'h1);
    check("mrst_sb_empty", 32'(sb.size()), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    push_t1();
    issue(1'b0, 4'd2, 6'd0, 6'd3, 1'b0);
    wait_idle();

    // T8 length beyond the vreg size keeps wrapping (vreg0: addr == beat index)
    push(11'h01F, 1'b0);
    for (int i = 0; i < 32; i++) push(11'(i), (i == 31));
    issue(1'b0, 4'd0, 6'd31, 6'd32, 1'b0);
    wait_idle();

    // T9 top areg wraps from beat 63 to beat 0
    push(11'h5FF, 1'b0);
    push(11'h5C0, 1'b1);
    issue(1'b1, 4'd15, 6'd63, 6'd1, 1'b0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
